// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the configurable UART receiver.
//   - uart_state_e : receiver FSM state encoding (also exported on the
//                    receiver's state debug port)
//   - PAR_*        : parity-mode constants for the PARITY parameter
//   - maj3()       : 2-of-3 majority vote used for mid-bit sampling
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PAR     = 3'd3,
        ST_STOP    = 3'd4,
        ST_WAIT_HI = 3'd5
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// ---------------------------------------------------------------------------
// baud_tick_gen
//   Free-running oversample tick generator. tick is a registered one-clock
//   pulse issued once every BAUD_DIV clocks.
//
//   Parameters:
//     BAUD_DIV : clk cycles per tick (>= 2)
//   Ports:
//     clk   : rising-edge clock
//     reset : asynchronous active-low reset
//     tick  : one-clock pulse, period BAUD_DIV clocks
// ---------------------------------------------------------------------------
module baud_tick_gen #(
    parameter int BAUD_DIV = 163
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            tick <= (cnt == CNT_LAST);
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// uart_rx_cfg
//   Oversampling UART receiver with configurable word length, parity and
//   stop-bit length, a one-entry output buffer and sticky overrun flag.
//
//   Parameters:
//     DBIT     : data bits per frame (5..9)
//     OS       : oversample ticks per bit (even, 8..32)
//     BAUD_DIV : clk cycles per oversample tick (>= 2)
//     PARITY   : 0 none, 1 even, 2 odd
//     SB_TICKS : stop-bit length in ticks (OS, 1.5*OS or 2*OS)
//   Ports:
//     clk        : rising-edge clock
//     reset      : asynchronous active-low reset
//     rx         : asynchronous serial line, idle high
//     dout       : received word, LSB is the first bit on the line
//     dout_valid : dout / parity_err / frame_err hold a word
//     dout_ready : consumer accepts the held word
//     parity_err : parity mismatch for the held word (0 when PARITY=0)
//     frame_err  : stop bit sampled low for the held word
//     overrun    : sticky, a completed frame was dropped (buffer full)
//     busy       : FSM is not in IDLE
//     state      : FSM state, for debug observation
//
//   Handshake: a word is transferred on any rising edge where dout_valid
//   and dout_ready are both high. dout_valid may not drop without that
//   transfer, and dout / parity_err / frame_err do not change while
//   dout_valid is high unless a transfer happens on the same edge.
// ---------------------------------------------------------------------------
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DBIT     = 8,
    parameter int OS       = 16,
    parameter int BAUD_DIV = 163,
    parameter int PARITY   = 0,
    parameter int SB_TICKS = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic            parity_err,
    output logic            frame_err,
    output logic            overrun,
    output logic            busy,
    output uart_state_e     state
);

    // Tick positions inside a bit (ticks numbered 0..OS-1 from bit start).
    localparam logic [5:0] T_MID_LO  = 6'(OS / 2 - 1);
    localparam logic [5:0] T_MID     = 6'(OS / 2);
    localparam logic [5:0] T_MID_HI  = 6'(OS / 2 + 1);
    localparam logic [5:0] T_LAST    = 6'(OS - 1);
    localparam logic [5:0] T_SB_LAST = 6'(SB_TICKS - 1);
    localparam logic [3:0] B_LAST    = 4'(DBIT - 1);

    logic            tick;
    logic            sync1;
    logic            rx_s;
    logic            rx_prev;
    logic [5:0]      tick_cnt;
    logic [3:0]      bit_cnt;
    logic            lead;
    logic [1:0]      smp;
    logic [DBIT-1:0] shreg;
    logic            par_bit;
    logic            stop_bit;
    logic            in_bit;
    logic            vote;
    logic            done;
    logic            hs;
    logic            perr_calc;

    baud_tick_gen #(
        .BAUD_DIV(BAUD_DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    // Two-flop synchroniser plus one history flop for falling-edge detect.
    // All reset to 1 so that reset release never looks like a start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= rx;
            rx_s    <= sync1;
            rx_prev <= rx_s;
        end
    end

    // Sampling applies inside data (after the start-bit tail), parity and
    // stop bits. The third majority sample is the live synchronised value.
    assign in_bit = ((state == ST_DATA) && !lead) ||
                    (state == ST_PAR) || (state == ST_STOP);
    assign vote   = maj3(smp[0], smp[1], rx_s);

    assign done = (state == ST_STOP) && tick && (tick_cnt == T_SB_LAST);
    assign hs   = dout_valid && dout_ready;

    assign perr_calc = (PARITY != PAR_NONE) &&
                       ((^shreg ^ par_bit) != (PARITY == PAR_ODD));

    // Receiver FSM. START ends at mid start bit; DATA then begins with the
    // remaining half of the start bit (lead=1) so that every data bit window
    // is aligned to the bit boundary and mid-bit sampling stays centred.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            lead     <= 1'b0;
            smp      <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            stop_bit <= 1'b1;
        end else begin
            if (tick && in_bit) begin
                if (tick_cnt == T_MID_LO) begin
                    smp[0] <= rx_s;
                end
                if (tick_cnt == T_MID) begin
                    smp[1] <= rx_s;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        state    <= ST_START;
                        busy     <= 1'b1;
                        tick_cnt <= '0;
                    end
                end

                ST_START: begin
                    if (tick) begin
                        if (tick_cnt == T_MID_LO) begin
                            if (rx_s) begin
                                // Line went back high: glitch, not a frame.
                                state    <= ST_IDLE;
                                busy     <= 1'b0;
                                tick_cnt <= '0;
                            end else begin
                                state    <= ST_DATA;
                                tick_cnt <= T_MID;
                                bit_cnt  <= '0;
                                lead     <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 6'd1;
                        end
                    end
                end

                ST_DATA: begin
                    if (tick) begin
                        if (!lead && (tick_cnt == T_MID_HI)) begin
                            shreg <= {vote, shreg[DBIT-1:1]};
                        end
                        if (tick_cnt == T_LAST) begin
                            tick_cnt <= '0;
                            if (lead) begin
                                lead <= 1'b0;
                            end else if (bit_cnt == B_LAST) begin
                                bit_cnt <= '0;
                                state   <= (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 6'd1;
                        end
                    end
                end

                ST_PAR: begin
                    if (tick) begin
                        if (tick_cnt == T_MID_HI) begin
                            par_bit <= vote;
                        end
                        if (tick_cnt == T_LAST) begin
                            tick_cnt <= '0;
                            state    <= ST_STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 6'd1;
                        end
                    end
                end

                ST_STOP: begin
                    if (tick) begin
                        if (tick_cnt == T_MID_HI) begin
                            stop_bit <= vote;
                        end
                        if (tick_cnt == T_SB_LAST) begin
                            tick_cnt <= '0;
                            // A low stop bit (including a break) must see the
                            // line return high before a new start is hunted.
                            if (!stop_bit) begin
                                state <= ST_WAIT_HI;
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 6'd1;
                        end
                    end
                end

                ST_WAIT_HI: begin
                    if (rx_s) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    tick_cnt <= '0;
                end
            endcase
        end
    end

    // One-entry output buffer. A completed frame is loaded when the buffer
    // is empty or is being emptied on the same edge; otherwise it is dropped
    // and overrun latches until the next transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (done) begin
            if (!dout_valid || dout_ready) begin
                dout       <= shreg;
                parity_err <= perr_calc;
                frame_err  <= !stop_bit;
                dout_valid <= 1'b1;
                if (hs) begin
                    overrun <= 1'b0;
                end
            end else begin
                overrun <= 1'b1;
            end
        end else if (hs) begin
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_cfg
//   Directed bench for uart_rx_cfg with BAUD_DIV=4, OS=16 (64 clks per bit).
//   u_dut is 8N1, u_dut_par is 8E1. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_uart_rx_cfg;
    import uart_pkg::*;

    localparam int BIT_CLKS = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx0 = 1'b1;
    logic        rx1 = 1'b1;
    logic        ready0 = 1'b1;
    logic        ready1 = 1'b1;
    logic [7:0]  dout0, dout1;
    logic        dv0, dv1, pe0, pe1, fe0, fe1, ov0, ov1, busy0, busy1;
    uart_state_e state0, state1;

    int   n_checks = 0;
    int   n_fail = 0;
    int   rise0 = 0;
    logic dv0_q = 1'b0;

    uart_rx_cfg #(
        .DBIT(8), .OS(16), .BAUD_DIV(4), .PARITY(0), .SB_TICKS(16)
    ) u_dut (
        .clk(clk), .reset(reset), .rx(rx0),
        .dout(dout0), .dout_valid(dv0), .dout_ready(ready0),
        .parity_err(pe0), .frame_err(fe0), .overrun(ov0),
        .busy(busy0), .state(state0)
    );

    uart_rx_cfg #(
        .DBIT(8), .OS(16), .BAUD_DIV(4), .PARITY(1), .SB_TICKS(16)
    ) u_dut_par (
        .clk(clk), .reset(reset), .rx(rx1),
        .dout(dout1), .dout_valid(dv1), .dout_ready(ready1),
        .parity_err(pe1), .frame_err(fe1), .overrun(ov1),
        .busy(busy1), .state(state1)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // Count rising edges of dout_valid on the 8N1 instance.
    always @(negedge clk) begin
        if (dv0 === 1'b1 && dv0_q !== 1'b1) rise0++;
        dv0_q = dv0;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic set_rx(input int which, input logic v);
        if (which == 0) rx0 = v;
        else            rx1 = v;
    endtask

    // One bit time; optional 4-clk (one tick) inversion at mid-bit.
    task automatic drive_bit(input int which, input logic v, input bit glitch);
        for (int c = 0; c < BIT_CLKS; c++) begin
            set_rx(which, (glitch && c >= 32 && c < 36) ? ~v : v);
            @(negedge clk);
        end
    endtask

    // Start, 8 data bits LSB first, optional parity, then half a stop bit;
    // the line is left high so completion is observed by wait_valid.
    task automatic send_frame(input int which, input logic [7:0] data,
                              input bit use_par, input logic par, input int glitch_idx);
        drive_bit(which, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(which, data[i], glitch_idx == i);
        if (use_par) drive_bit(which, par, 1'b0);
        for (int c = 0; c < BIT_CLKS / 2; c++) begin
            set_rx(which, 1'b1);
            @(negedge clk);
        end
    endtask

    task automatic wait_valid(input int which, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if ((which == 0 && dv0 === 1'b1) || (which == 1 && dv1 === 1'b1)) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit seen;
        int r;

        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_dout", dout0, 8'h00);
        check_eq("rst_valid", dv0, 1'b0);
        check_eq("rst_perr", pe0, 1'b0);
        check_eq("rst_ferr", fe0, 1'b0);
        check_eq("rst_ovr", ov0, 1'b0);
        check_eq("rst_busy", busy0, 1'b0);
        check_eq("rst_state", state0, ST_IDLE);
        check_eq("rst_valid_par", dv1, 1'b0);
        reset = 1'b1;
        repeat (10) @(negedge clk);

        // 8N1 0x55 with ready high: one-clock valid, no errors
        send_frame(0, 8'h55, 1'b0, 1'b0, -1);
        wait_valid(0, 80, seen);
        check_eq("f55_seen", seen, 1'b1);
        check_eq("f55_dout", dout0, 8'h55);
        check_eq("f55_perr", pe0, 1'b0);
        check_eq("f55_ferr", fe0, 1'b0);
        @(negedge clk);
        check_eq("f55_one_clk", dv0, 1'b0);
        repeat (20) @(negedge clk);
        check_eq("f55_idle", busy0, 1'b0);

        // Even parity, 0xA3 has four ones: parity bit 1 is wrong, 0 is right
        send_frame(1, 8'hA3, 1'b1, 1'b1, -1);
        wait_valid(1, 80, seen);
        check_eq("pbad_seen", seen, 1'b1);
        check_eq("pbad_dout", dout1, 8'hA3);
        check_eq("pbad_perr", pe1, 1'b1);
        check_eq("pbad_ferr", fe1, 1'b0);
        repeat (20) @(negedge clk);
        send_frame(1, 8'hA3, 1'b1, 1'b0, -1);
        wait_valid(1, 80, seen);
        check_eq("pok_seen", seen, 1'b1);
        check_eq("pok_dout", dout1, 8'hA3);
        check_eq("pok_perr", pe1, 1'b0);
        repeat (20) @(negedge clk);

        // False start: 5 ticks low
        r = rise0;
        rx0 = 1'b0;
        repeat (16) @(negedge clk);
        check_eq("fs_busy", busy0, 1'b1);
        repeat (4) @(negedge clk);
        rx0 = 1'b1;
        repeat (100) @(negedge clk);
        check_eq("fs_busy_low", busy0, 1'b0);
        check_eq("fs_no_valid", rise0, r);
        send_frame(0, 8'h0F, 1'b0, 1'b0, -1);
        wait_valid(0, 80, seen);
        check_eq("f0f_seen", seen, 1'b1);
        check_eq("f0f_dout", dout0, 8'h0F);
        repeat (20) @(negedge clk);

        // Overrun: consumer stalled across two frames
        ready0 = 1'b0;
        r = rise0;
        send_frame(0, 8'h11, 1'b0, 1'b0, -1);
        wait_valid(0, 80, seen);
        check_eq("ov_first_seen", seen, 1'b1);
        check_eq("ov_first_dout", dout0, 8'h11);
        repeat (20) @(negedge clk);
        send_frame(0, 8'h22, 1'b0, 1'b0, -1);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (ov0 === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("ov_set", seen, 1'b1);
        check_eq("ov_dout_held", dout0, 8'h11);
        check_eq("ov_valid_held", dv0, 1'b1);
        check_eq("ov_rises", rise0, r + 1);
        ready0 = 1'b1;
        @(negedge clk);
        check_eq("ov_consumed", dv0, 1'b0);
        check_eq("ov_cleared", ov0, 1'b0);
        repeat (20) @(negedge clk);

        // Break: line low for 20 bit times
        ready0 = 1'b0;
        r = rise0;
        rx0 = 1'b0;
        wait_valid(0, 900, seen);
        check_eq("brk_seen", seen, 1'b1);
        check_eq("brk_dout", dout0, 8'h00);
        check_eq("brk_ferr", fe0, 1'b1);
        repeat (600) @(negedge clk);
        check_eq("brk_wait_hi", state0, ST_WAIT_HI);
        check_eq("brk_busy", busy0, 1'b1);
        check_eq("brk_single", rise0, r + 1);
        rx0 = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("brk_released", busy0, 1'b0);
        ready0 = 1'b1;
        @(negedge clk);
        check_eq("brk_consumed", dv0, 1'b0);
        repeat (20) @(negedge clk);

        // One-tick glitches at mid-bit on a 1 bit and on a 0 bit
        send_frame(0, 8'hA5, 1'b0, 1'b0, 2);
        wait_valid(0, 80, seen);
        check_eq("gl1_seen", seen, 1'b1);
        check_eq("gl1_dout", dout0, 8'hA5);
        check_eq("gl1_ferr", fe0, 1'b0);
        repeat (20) @(negedge clk);
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1);
        wait_valid(0, 80, seen);
        check_eq("gl0_seen", seen, 1'b1);
        check_eq("gl0_dout", dout0, 8'hA5);
        repeat (20) @(negedge clk);

        // Reset in the middle of the data bits aborts the frame
        r = rise0;
        drive_bit(0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(0, 1'b1, 1'b0);
        check_eq("mid_busy", busy0, 1'b1);
        reset = 1'b0;
        rx0 = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (15 * BIT_CLKS) @(negedge clk);
        check_eq("mid_no_valid", rise0, r);
        check_eq("mid_valid_low", dv0, 1'b0);
        check_eq("mid_busy_low", busy0, 1'b0);
        check_eq("mid_dout_zero", dout0, 8'h00);
        send_frame(0, 8'h3C, 1'b0, 1'b0, -1);
        wait_valid(0, 80, seen);
        check_eq("post_rst_seen", seen, 1'b1);
        check_eq("post_rst_dout", dout0, 8'h3C);

        repeat (20) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter DBIT, 8, data bits per frame, legal 5..9.
REQ-002 SHALL have parameter OS, 16, oversampling ticks per bit, even, legal 8..32.
REQ-003 SHALL have parameter BAUD_DIV, 163, clk cycles per oversample tick, legal >=2.
REQ-004 SHALL have parameter PARITY, 0, 0 none / 1 even / 2 odd.
REQ-005 SHALL have parameter SB_TICKS, 16, stop-bit length in ticks: OS, 1.5*OS or 2*OS.
REQ-006 SHALL have port clk, in, 1, single clock; all logic on rising edge.
REQ-007 SHALL have port reset, in, 1, asynchronous active-low reset.
REQ-008 SHALL have port rx, in, 1, asynchronous serial line, idle high.
REQ-009 SHALL have port dout, out, DBIT, received word, LSB = first bit received.
REQ-010 SHALL have port dout_valid, out, 1, dout and error flags held and valid.
REQ-011 SHALL have port dout_ready, in, 1, consumer accepts word when high with dout_valid.
REQ-012 SHALL have port parity_err, out, 1, parity mismatch for the held word; 0 when PARITY=0.
REQ-013 SHALL have port frame_err, out, 1, stop bit sampled low for the held word.
REQ-014 SHALL have port overrun, out, 1, sticky: a frame was dropped because the buffer was full.
REQ-015 SHALL have port busy, out, 1, high in every state except IDLE.

Function
REQ-016 SHALL pass rx through a 2-flop synchroniser; all logic uses the synchronised value.
REQ-017 SHALL generate an oversample tick: one-clk pulse every BAUD_DIV clks, free-running.
REQ-018 SHALL implement FSM states IDLE, START, DATA, PAR, STOP, WAIT_HI.
REQ-019 IDLE -> START on synchronised rx 1->0; tick counter cleared.
REQ-020 START: after OS/2 ticks sample rx; high = false start -> IDLE, no output; low -> DATA.
REQ-021 DATA: each bit takes OS ticks; value = majority of samples at ticks OS/2-1, OS/2, OS/2+1 of the bit.
REQ-022 DATA shifts bits in LSB first; after DBIT bits -> PAR if PARITY!=0, else STOP.
REQ-023 PAR: one bit, majority-sampled; parity_err = (XOR of data bits XOR parity bit) != (PARITY==2).
REQ-024 STOP: sample first stop bit at mid-bit (majority); wait SB_TICKS total; low sample sets frame_err.
REQ-025 Frame completes at the tick ending SB_TICKS; dout_valid rises on the next clk edge.
REQ-026 After a frame_err completion -> WAIT_HI until rx high, then IDLE; otherwise -> IDLE directly.
REQ-027 Output buffer is one entry; dout, parity_err and frame_err are stable while dout_valid is high.
REQ-028 Handshake: word consumed on a clk edge with dout_valid && dout_ready; dout_valid then drops.
REQ-029 Completion with buffer full and no handshake that cycle: new frame dropped, old word kept, overrun set.
REQ-030 Completion and handshake on the same edge: new word loaded, dout_valid stays high, no overrun.
REQ-031 overrun clears on the edge of the next handshake.
REQ-032 Break (rx low >= full frame) SHALL yield dout=0, frame_err=1, then WAIT_HI.

Reset
REQ-033 reset low SHALL force state IDLE, counters 0, synchroniser flops 1 and shift register 0.
REQ-034 reset low SHALL force dout=0, dout_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
REQ-035 Reset asserted mid-frame SHALL abort the frame with no dout_valid after release.

Structure
REQ-036 Package uart_pkg SHALL hold the FSM state enum, parity-mode constants and the majority-vote function.
REQ-037 Tick generation SHALL be sub-module baud_tick_gen (parameter BAUD_DIV; ports clk, reset, tick).

Verification (BAUD_DIV=4, OS=16 unless stated)
REQ-038 8N1 frame 0x55, dout_ready=1 -> dout=0x55, dout_valid for 1 clk, no errors.
REQ-039 PARITY=1, 0xA3 with parity bit 1 (wrong) -> dout=0xA3, parity_err=1; correct bit 0 -> parity_err=0.
REQ-040 rx low for 5 ticks only -> no dout_valid, busy returns low, next valid 0x0F frame received.
REQ-041 dout_ready=0, frames 0x11 then 0x22 -> dout=0x11 held, overrun=1; raise ready -> overrun=0.
REQ-042 rx held low 20 bit times -> dout=0x00, frame_err=1; no further frame until rx high.
REQ-043 Glitch: one bit sample 3 (of 16) inverted mid-bit for 1 tick -> word unaffected; reset mid-DATA -> no output.
